// File: rtl/fft_bfly_sequencer.sv
// ----------------------------------------------------------------------------
// fft_bfly_sequencer
//
// Control FSM for an in-place radix-2 decimation-in-time FFT core.
// A start pulse begins a transform. The FSM then walks LOG2N stages of N/2
// butterflies each. For every butterfly it presents the upper- and lower-leg
// sample addresses and the twiddle ROM index. After each stage, including the
// last one, it inserts PIPE_LAT idle cycles. This lets the datapath's
// pipelined write-back finish before the next stage reads the RAM.
//
// Optional feature (compile-time macro BITREV_LOAD_EN):
//   When the macro is defined, a LOAD phase runs between IDLE and RUN. In this
//   phase the block emits bit-reversed RAM write addresses for the input
//   samples. When the macro is undefined, load_valid and load_addr are tied
//   to 0, load_ready is ignored, and the input must be written to the RAM
//   already in bit-reversed order.
//
// Parameters:
//   LOG2N     log2 of the FFT size N (legal range 2..10)
//   PIPE_LAT  flush cycles after each stage (0 is legal: no flush gap)
//
// Ports:
//   clk         in   single clock, all state changes on posedge
//   reset       in   synchronous, active-high
//   start       in   begin a transform; only looked at in IDLE
//   abort       in   cancel the transform; return to IDLE without a done pulse
//   bfly_ready  in   datapath accepts the butterfly currently presented
//   bfly_valid  out  addr_a/addr_b/tw_idx/stage describe a butterfly
//   addr_a      out  upper-leg sample address
//   addr_b      out  lower-leg sample address (addr_a + 2^stage)
//   tw_idx      out  twiddle ROM index
//   stage       out  current stage, 0..LOG2N-1
//   busy        out  a transform is in progress
//   done        out  one-cycle pulse when the transform completes
//   load_valid  out  input-load strobe (LOAD phase only)
//   load_addr   out  bit-reversed RAM write address during LOAD
//   load_ready  in   loader accepted load_addr
// ----------------------------------------------------------------------------
module fft_bfly_sequencer #(
    parameter int LOG2N    = 4,
    parameter int PIPE_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     bfly_ready,
    output logic                     bfly_valid,
    output logic [LOG2N-1:0]         addr_a,
    output logic [LOG2N-1:0]         addr_b,
    output logic [LOG2N-2:0]         tw_idx,
    output logic [$clog2(LOG2N)-1:0] stage,
    output logic                     busy,
    output logic                     done,
    output logic                     load_valid,
    output logic [LOG2N-1:0]         load_addr,
    input  logic                     load_ready
);

    localparam int N    = 1 << LOG2N;
    localparam int HALF = N / 2;
    localparam int SW   = $clog2(LOG2N);
    localparam int SW1  = SW + 1;
    localparam int BW   = LOG2N - 1;
    localparam int CW   = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT + 1);

    localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2N - 1);
    localparam logic [BW-1:0] LAST_BFLY  = BW'(HALF - 1);
    localparam logic [CW-1:0] CNT_INIT   = CW'(PIPE_LAT);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          state;
    logic [BW-1:0]   bfly;
    logic [CW-1:0]   cnt;

`ifdef BITREV_LOAD_EN
    localparam logic [LOG2N-1:0] LAST_LOAD = LOG2N'(N - 1);

    logic             load_valid_q;
    logic [LOG2N-1:0] load_idx;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    assign load_valid = load_valid_q;
    assign load_addr  = load_valid_q ? bitrev(load_idx) : '0;
`else
    logic unused_load_ready;

    assign unused_load_ready = load_ready;
    assign load_valid        = 1'b0;
    assign load_addr         = '0;
`endif

    // ------------------------------------------------------------------
    // Control FSM. busy/done/bfly_valid are registered alongside the state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || (abort && state != S_IDLE)) begin
            // Abort returns every register to its reset value.
            state      <= S_IDLE;
            stage      <= '0;
            bfly       <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bfly_valid <= 1'b0;
`ifdef BITREV_LOAD_EN
            load_idx     <= '0;
            load_valid_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        stage <= '0;
                        bfly  <= '0;
                        busy  <= 1'b1;
`ifdef BITREV_LOAD_EN
                        load_idx     <= '0;
                        load_valid_q <= 1'b1;
                        state        <= S_LOAD;
`else
                        bfly_valid <= 1'b1;
                        state      <= S_RUN;
`endif
                    end
                end

                S_LOAD: begin
`ifdef BITREV_LOAD_EN
                    if (load_ready) begin
                        if (load_idx == LAST_LOAD) begin
                            load_idx     <= '0;
                            load_valid_q <= 1'b0;
                            bfly_valid   <= 1'b1;
                            state        <= S_RUN;
                        end else begin
                            load_idx <= load_idx + LOG2N'(1);
                        end
                    end
`else
                    state <= S_IDLE;
`endif
                end

                S_RUN: begin
                    if (bfly_ready) begin
                        if (bfly == LAST_BFLY) begin
                            bfly <= '0;
                            if (PIPE_LAT == 0) begin
                                // No flush gap: apply the stage-exit rule now.
                                if (stage == LAST_STAGE) begin
                                    bfly_valid <= 1'b0;
                                    busy       <= 1'b0;
                                    done       <= 1'b1;
                                    state      <= S_DONE;
                                end else begin
                                    stage <= stage + SW'(1);
                                end
                            end else begin
                                bfly_valid <= 1'b0;
                                cnt        <= CNT_INIT;
                                state      <= S_FLUSH;
                            end
                        end else begin
                            bfly <= bfly + BW'(1);
                        end
                    end
                end

                S_FLUSH: begin
                    if (cnt <= CNT_ONE) begin
                        cnt <= '0;
                        if (stage == LAST_STAGE) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            stage      <= stage + SW'(1);
                            bfly_valid <= 1'b1;
                            state      <= S_RUN;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    stage <= '0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Butterfly address generation, combinational from stage/bfly.
    // bfly splits into a group index (upper bits) and a position inside
    // the group (lower 'stage' bits). Spreading the group index up by one
    // bit opens the slot for the lower leg at +span.
    // ------------------------------------------------------------------
    logic [LOG2N-1:0] bfly_w;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] grp;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] a_full;
    logic [BW-1:0]    tw_full;
    logic [SW1-1:0]   sh_a;
    logic [SW1-1:0]   sh_tw;

    always_comb begin
        bfly_w  = LOG2N'(bfly);
        span    = LOG2N'(1) << stage;
        grp     = bfly_w >> stage;
        pos     = bfly_w & (span - LOG2N'(1));
        // Shift amounts are widened by one bit so that stage+1 cannot wrap.
        sh_a    = {1'b0, stage} + SW1'(1);
        sh_tw   = SW1'(LOG2N - 1) - {1'b0, stage};
        a_full  = (grp << sh_a) | pos;
        tw_full = BW'(pos << sh_tw);
    end

    // Addresses are forced to 0 outside RUN, so idle and reset show all zeros.
    assign addr_a = bfly_valid ? a_full : '0;
    assign addr_b = bfly_valid ? (a_full | span) : '0;
    assign tw_idx = bfly_valid ? tw_full : '0;

endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fft_bfly_sequencer
//
// Randomized self-checking bench for fft_bfly_sequencer. It uses the default
// build, where BITREV_LOAD_EN is undefined.
//
// Two instances share the clock and the reset:
//   u_dut_s  PIPE_LAT=2 (default)
//   u_dut_z  PIPE_LAT=0
//
// For every transform the bench first builds the expected cycle-by-cycle
// trace from the FFT butterfly schedule. For stage s the span is 2^s. Group g
// and position p give the butterfly a = 2*span*g + p, b = a + span and
// twiddle p*N/(2*span). Random stall cycles on bfly_ready repeat the
// presented butterfly. Each stage is followed by PIPE_LAT idle cycles, then
// comes a done cycle and an idle cycle. The bench drives bfly_ready from that
// trace and compares the DUT against it.
// ----------------------------------------------------------------------------
module tb_fft_bfly_sequencer;

    localparam int LOG2N = 4;
    localparam int N     = 1 << LOG2N;
    localparam int HALF  = N / 2;
    localparam int PL    = 2;

    typedef struct {
        logic valid;
        int   a;
        int   b;
        int   tw;
        int   stg;
        logic busy;
        logic done;
        logic rdy;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       start_s, abort_s, ready_s, valid_s, busy_s, done_s, lvalid_s, lready_s;
    logic [3:0] a_s, b_s, laddr_s;
    logic [2:0] tw_s;
    logic [1:0] stg_s;

    logic       start_z, abort_z, ready_z, valid_z, busy_z, done_z, lvalid_z, lready_z;
    logic [3:0] a_z, b_z, laddr_z;
    logic [2:0] tw_z;
    logic [1:0] stg_z;

    fft_bfly_sequencer #(.LOG2N(LOG2N), .PIPE_LAT(PL)) u_dut_s (
        .clk(clk), .reset(reset), .start(start_s), .abort(abort_s),
        .bfly_ready(ready_s), .bfly_valid(valid_s), .addr_a(a_s), .addr_b(b_s),
        .tw_idx(tw_s), .stage(stg_s), .busy(busy_s), .done(done_s),
        .load_valid(lvalid_s), .load_addr(laddr_s), .load_ready(lready_s)
    );

    fft_bfly_sequencer #(.LOG2N(LOG2N), .PIPE_LAT(0)) u_dut_z (
        .clk(clk), .reset(reset), .start(start_z), .abort(abort_z),
        .bfly_ready(ready_z), .bfly_valid(valid_z), .addr_a(a_z), .addr_b(b_z),
        .tw_idx(tw_z), .stage(stg_z), .busy(busy_z), .done(done_z),
        .load_valid(lvalid_z), .load_addr(laddr_z), .load_ready(lready_z)
    );

    int   checks = 0;
    int   errors = 0;
    ent_t tl[$];
    int   tot_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic ab, input logic rd);
        if (sel == 0) begin
            start_s = st; abort_s = ab; ready_s = rd; lready_s = 1'b1;
        end else begin
            start_z = st; abort_z = ab; ready_z = rd; lready_z = 1'b1;
        end
    endtask

    task automatic observe(input int sel, output ent_t o);
        if (sel == 0) begin
            o.valid = valid_s; o.a = int'(a_s); o.b = int'(b_s); o.tw = int'(tw_s);
            o.stg = int'(stg_s); o.busy = busy_s; o.done = done_s; o.rdy = ready_s;
        end else begin
            o.valid = valid_z; o.a = int'(a_z); o.b = int'(b_z); o.tw = int'(tw_z);
            o.stg = int'(stg_z); o.busy = busy_z; o.done = done_z; o.rdy = ready_z;
        end
    endtask

    task automatic check_zero(input int sel);
        if (sel == 0) begin
            chk("rst_valid", valid_s, 0);  chk("rst_busy", busy_s, 0);
            chk("rst_done", done_s, 0);    chk("rst_a", a_s, 0);
            chk("rst_b", b_s, 0);          chk("rst_tw", tw_s, 0);
            chk("rst_stage", stg_s, 0);    chk("rst_lvalid", lvalid_s, 0);
            chk("rst_laddr", laddr_s, 0);
        end else begin
            chk("rst_valid_z", valid_z, 0); chk("rst_busy_z", busy_z, 0);
            chk("rst_done_z", done_z, 0);   chk("rst_a_z", a_z, 0);
            chk("rst_b_z", b_z, 0);         chk("rst_tw_z", tw_z, 0);
            chk("rst_stage_z", stg_z, 0);   chk("rst_lvalid_z", lvalid_z, 0);
            chk("rst_laddr_z", laddr_z, 0);
        end
    endtask

    // mode 0: no stalls, 1: random stalls, 2: 3-cycle stall at stage 1 bfly 3
    task automatic build(input int plat, input int mode);
        ent_t e;
        int   span, nst, idx;
        tl.delete();
        tot_stall = 0;
        for (int s = 0; s < LOG2N; s++) begin
            span = 1 << s;
            for (int g = 0; g < N / (2 * span); g++) begin
                for (int p = 0; p < span; p++) begin
                    idx     = g * span + p;
                    e.valid = 1'b1;
                    e.a     = 2 * span * g + p;
                    e.b     = e.a + span;
                    e.tw    = p * (N / (2 * span));
                    e.stg   = s;
                    e.busy  = 1'b1;
                    e.done  = 1'b0;
                    nst = 0;
                    if (mode == 1 && $urandom_range(0, 3) == 0) nst = int'($urandom_range(1, 3));
                    if (mode == 2 && s == 1 && idx == 3) nst = 3;
                    for (int r = 0; r < nst; r++) begin
                        e.rdy = 1'b0;
                        tl.push_back(e);
                        tot_stall++;
                    end
                    e.rdy = 1'b1;
                    tl.push_back(e);
                end
            end
            for (int f = 0; f < plat; f++) begin
                e.valid = 1'b0; e.a = 0; e.b = 0; e.tw = 0; e.stg = s;
                e.busy = 1'b1; e.done = 1'b0; e.rdy = 1'(int'($urandom_range(0, 1)));
                tl.push_back(e);
            end
        end
        e.valid = 1'b0; e.stg = LOG2N - 1; e.busy = 1'b0; e.done = 1'b1;
        e.rdy = 1'(int'($urandom_range(0, 1)));
        tl.push_back(e);
        e.stg = -1; e.done = 1'b0;
        tl.push_back(e);
    endtask

    task automatic run(input int sel, input int plat, input int mode,
                       input int abort_at, input int rst_at);
        ent_t       e, o;
        int         done_at;
        logic [N-1:0] cov [LOG2N];
        int         cnt [LOG2N];
        for (int s = 0; s < LOG2N; s++) begin
            cov[s] = '0;
            cnt[s] = 0;
        end
        build(plat, mode);
        done_at = -1;
        @(negedge clk);
        drive(sel, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        for (int i = 0; i < tl.size(); i++) begin
            @(negedge clk);
            e = tl[i];
            observe(sel, o);
            chk("valid", o.valid, e.valid);
            chk("busy", o.busy, e.busy);
            chk("done", o.done, e.done);
            if (e.stg >= 0) chk("stage", o.stg, e.stg);
            if (e.valid) begin
                chk("addr_a", o.a, e.a);
                chk("addr_b", o.b, e.b);
                chk("tw_idx", o.tw, e.tw);
            end
            if (o.done === 1'b1 && done_at < 0) done_at = i + 1;
            if (o.valid === 1'b1 && e.rdy && o.stg < LOG2N && o.a < N && o.b < N) begin
                cov[o.stg][o.a] = 1'b1;
                cov[o.stg][o.b] = 1'b1;
                cnt[o.stg] += 2;
            end
            if (i == abort_at) begin
                drive(sel, 1'b0, 1'b1, 1'b1);
                @(negedge clk);
                observe(sel, o);
                chk("abort_busy", o.busy, 0);
                chk("abort_valid", o.valid, 0);
                chk("abort_done", o.done, 0);
                drive(sel, 1'b0, 1'b0, 1'b1);
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    observe(sel, o);
                    chk("abort_nodone", o.done, 0);
                    chk("abort_idle", o.busy, 0);
                end
                return;
            end
            if (i == rst_at) begin
                drive(sel, 1'b0, 1'b0, 1'b1);
                reset = 1'b1;
                @(negedge clk);
                check_zero(sel);
                reset = 1'b0;
                return;
            end
            // Random start pulses while busy or in the done cycle are ignored.
            drive(sel, (e.busy || e.done) ? 1'(int'($urandom_range(0, 1))) : 1'b0, 1'b0, e.rdy);
        end
        chk("done_lat", done_at, 1 + LOG2N * (HALF + plat) + tot_stall);
        for (int s = 0; s < LOG2N; s++) begin
            chk("cover_mask", cov[s], {N{1'b1}});
            chk("cover_cnt", cnt[s], N);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero(0);
        check_zero(1);
        reset = 1'b0;

        run(0, PL, 0, -1, -1);               // plain transform, done at k+41
        run(0, PL, 2, -1, -1);               // 3-cycle stall, done at k+44
        for (int r = 0; r < 3; r++) run(0, PL, 1, -1, -1);
        run(0, PL, 0, 2 * (HALF + PL) + 3, -1);  // abort in stage 2
        run(0, PL, 0, -1, -1);               // fresh start after abort
        run(0, PL, 0, -1, HALF + PL + HALF); // reset in stage 1 flush
        run(0, PL, 1, -1, -1);
        run(1, 0, 0, -1, -1);                // PIPE_LAT=0, done at k+33
        run(1, 0, 1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
